// File: rtl/or1200_vlx_lu_pkg.sv
// Shared types and constants for the VLX load unit.
// The FSM encoding gains CHK_FF/MARKER when OR1200_VLX_LU_UNSTUFF_EN is defined.
package or1200_vlx_pkg;

    localparam int VLX_BUF_W        = 32;
    localparam int VLX_FETCH_THRESH = 24;
    localparam logic [7:0] VLX_STUFF_BYTE = 8'hFF;
    localparam int VLX_MAX_POP      = 16;

`ifdef OR1200_VLX_LU_UNSTUFF_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_CHK_FF = 2'd2,
        ST_MARKER = 2'd3
    } vlx_lu_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1
    } vlx_lu_state_t;
`endif

    // A pop is honoured only for 1..VLX_MAX_POP bits that are actually present.
    function automatic logic vlx_pop_legal(input logic [4:0] n, input logic [5:0] avail);
        return (n != 5'd0) && (n <= 5'(VLX_MAX_POP)) && ({1'b0, n} <= avail);
    endfunction

endpackage

// File: rtl/or1200_vlx_lu_if.sv
// Bus bundle of the VLX load unit: control, byte-fetch port and bit-consumer port.
interface or1200_vlx_lu_if;

    logic        set_init_addr_i;
    logic [31:0] dat_i;
    logic [31:0] vlx_addr_o;
    logic        load_req_o;
    logic        ack_i;
    logic [7:0]  mem_dat_i;
    logic        get_bits_i;
    logic [4:0]  nbits_i;
    logic [15:0] bits_o;
    logic [5:0]  avail_o;
    logic        marker_o;

    modport slave (
        input  set_init_addr_i, dat_i, ack_i, mem_dat_i, get_bits_i, nbits_i,
        output vlx_addr_o, load_req_o, bits_o, avail_o, marker_o
    );

    modport master (
        output set_init_addr_i, dat_i, ack_i, mem_dat_i, get_bits_i, nbits_i,
        input  vlx_addr_o, load_req_o, bits_o, avail_o, marker_o
    );

endinterface

// File: rtl/or1200_vlx_lu_bitbuf.sv
// 32-bit MSB-first bit buffer with valid count; pop applies before push/drop in a cycle.
module or1200_vlx_bitbuf
    import or1200_vlx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    input  logic        pop_i,
    input  logic [4:0]  n_i,
    input  logic        drop_i,
    output logic [15:0] bits_o,
    output logic [5:0]  avail_o
);

    logic [VLX_BUF_W-1:0] buf_r;
    logic [VLX_BUF_W-1:0] buf_nx_s;
    logic [5:0]           avail_r;
    logic [5:0]           avail_nx_s;

    // Next buffer contents: clear, else shift-out, append at the tail, then optional tail drop.
    always_comb begin
        buf_nx_s   = buf_r;
        avail_nx_s = avail_r;
        if (clr_i) begin
            buf_nx_s   = '0;
            avail_nx_s = 6'd0;
        end else begin
            if (pop_i && vlx_pop_legal(n_i, avail_r)) begin
                buf_nx_s   = buf_r << n_i;
                avail_nx_s = avail_r - {1'b0, n_i};
            end else begin
                buf_nx_s   = buf_r;
                avail_nx_s = avail_r;
            end
            if (push_i && (avail_nx_s <= 6'(VLX_FETCH_THRESH))) begin
                buf_nx_s   = buf_nx_s | ({byte_i, 24'h000000} >> avail_nx_s);
                avail_nx_s = avail_nx_s + 6'd8;
            end else begin
                avail_nx_s = avail_nx_s;
            end
            // Bits below the valid count are kept zero so appends can simply OR in.
            if (drop_i) begin
                avail_nx_s = (avail_nx_s >= 6'd8) ? (avail_nx_s - 6'd8) : 6'd0;
                buf_nx_s   = buf_nx_s & ~(32'hFFFF_FFFF >> avail_nx_s);
            end else begin
                buf_nx_s   = buf_nx_s;
            end
        end
    end

    // Buffer and count registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            buf_r   <= '0;
            avail_r <= 6'd0;
        end else begin
            buf_r   <= buf_nx_s;
            avail_r <= avail_nx_s;
        end
    end

    assign bits_o  = buf_r[VLX_BUF_W-1 -: 16];
    assign avail_o = avail_r;

endmodule

// File: rtl/or1200_vlx_lu.sv
// VLX load unit: fetches bytes into the bit buffer for the Huffman decoder.
// Define OR1200_VLX_LU_UNSTUFF_EN to remove 0xFF00 stuffing and stop on markers.
module or1200_vlx_lu
    import or1200_vlx_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    or1200_vlx_lu_if.slave    bus
);

    vlx_lu_state_t state_r;
    vlx_lu_state_t state_nx_s;
    logic [31:0]   addr_r;
    logic [31:0]   addr_nx_s;
    logic          load_req_r;
    logic          load_req_nx_s;
    logic          marker_r;
    logic          marker_nx_s;
    logic          ack_v_s;
    logic          push_s;
    logic          drop_s;
    logic [5:0]    avail_s;

    // An ack only counts while our request is actually on the bus.
    assign ack_v_s = bus.ack_i && load_req_r;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state, next-address and buffer control.
    always_comb begin
        state_nx_s = state_r;
        addr_nx_s  = addr_r;
        push_s     = 1'b0;
        drop_s     = 1'b0;
        if (bus.set_init_addr_i) begin
            state_nx_s = ST_REQ;
            addr_nx_s  = bus.dat_i;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (avail_s <= 6'(VLX_FETCH_THRESH)) begin
                        state_nx_s = ST_REQ;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (ack_v_s) begin
                        push_s    = 1'b1;
                        addr_nx_s = addr_r + 32'd1;
`ifdef OR1200_VLX_LU_UNSTUFF_EN
                        if (bus.mem_dat_i == VLX_STUFF_BYTE) begin
                            state_nx_s = ST_CHK_FF;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
`else
                        state_nx_s = ST_IDLE;
`endif
                    end else begin
                        state_nx_s = ST_REQ;
                    end
                end
`ifdef OR1200_VLX_LU_UNSTUFF_EN
                // A stuffed zero is skipped; anything else is a marker, and the
                // preceding 0xFF was not data after all.
                ST_CHK_FF: begin
                    if (ack_v_s) begin
                        if (bus.mem_dat_i == 8'h00) begin
                            addr_nx_s  = addr_r + 32'd1;
                            state_nx_s = ST_IDLE;
                        end else begin
                            drop_s     = 1'b1;
                            state_nx_s = ST_MARKER;
                        end
                    end else begin
                        state_nx_s = ST_CHK_FF;
                    end
                end
                ST_MARKER: begin
                    state_nx_s = ST_MARKER;
                end
`endif
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode; a restart forces one idle request cycle before the new fetch.
    always_comb begin
        load_req_nx_s = 1'b0;
        marker_nx_s   = 1'b0;
        if (bus.set_init_addr_i) begin
            load_req_nx_s = 1'b0;
        end else begin
`ifdef OR1200_VLX_LU_UNSTUFF_EN
            load_req_nx_s = (state_nx_s == ST_REQ) || (state_nx_s == ST_CHK_FF);
            marker_nx_s   = (state_nx_s == ST_MARKER);
`else
            load_req_nx_s = (state_nx_s == ST_REQ);
`endif
        end
    end

    // Registered outputs and address.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_r     <= 32'd0;
            load_req_r <= 1'b0;
            marker_r   <= 1'b0;
        end else begin
            addr_r     <= addr_nx_s;
            load_req_r <= load_req_nx_s;
            marker_r   <= marker_nx_s;
        end
    end

    or1200_vlx_bitbuf u_bitbuf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (bus.set_init_addr_i),
        .push_i  (push_s),
        .byte_i  (bus.mem_dat_i),
        .pop_i   (bus.get_bits_i),
        .n_i     (bus.nbits_i),
        .drop_i  (drop_s),
        .bits_o  (bus.bits_o),
        .avail_o (avail_s)
    );

    assign bus.avail_o    = avail_s;
    assign bus.vlx_addr_o = addr_r;
    assign bus.load_req_o = load_req_r;
    assign bus.marker_o   = marker_r;

endmodule

// File: tb/tb_or1200_vlx_lu.sv
// Directed bench for or1200_vlx_lu; a bit-queue model feeds a scoreboard of expected bits/avail.
module tb_or1200_vlx_lu;

    logic clk_i = 1'b0;
    logic rst_i;

    or1200_vlx_lu_if bus_if ();

    or1200_vlx_lu dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_if)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          model_q[$];
    logic [31:0] exp_addr;
    string       tag_q[$];
    int          kind_q[$];
    logic [31:0] val_q[$];

    localparam int ACT_APPEND  = 0;
    localparam int ACT_DISCARD = 1;
    localparam int ACT_MARKER  = 2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_bits();
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[15-i] = (i < model_q.size()) ? model_q[i] : 1'b0;
        return r;
    endfunction

    task automatic model_pop(input logic [4:0] n);
        if (n != 5'd0 && n <= 5'd16 && int'(n) <= model_q.size())
            for (int i = 0; i < int'(n); i++) void'(model_q.pop_front());
    endtask

    task automatic model_push(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) model_q.push_back(d[i]);
    endtask

    task automatic model_drop();
        for (int i = 0; i < 8; i++) if (model_q.size() > 0) void'(model_q.pop_back());
    endtask

    task automatic sb_push(input string tag);
        tag_q.push_back({tag, "_bits"});  kind_q.push_back(0); val_q.push_back(32'(model_bits()));
        tag_q.push_back({tag, "_avail"}); kind_q.push_back(1); val_q.push_back(32'(model_q.size()));
    endtask

    task automatic sb_check();
        while (val_q.size() > 0) begin
            string       t;
            int          k;
            logic [31:0] v;
            t = tag_q.pop_front();
            k = kind_q.pop_front();
            v = val_q.pop_front();
            if (k == 0) chk(t, 32'(bus_if.bits_o), v);
            else        chk(t, 32'(bus_if.avail_o), v);
        end
    endtask

    task automatic wait_req(input string tag);
        int w;
        w = 0;
        while (bus_if.load_req_o !== 1'b1 && w < 20) begin
            @(posedge clk_i); #1;
            w++;
        end
        chk({tag, "_req"}, 32'(bus_if.load_req_o), 32'd1);
    endtask

    task automatic fetch(input string tag, input logic [7:0] d, input int act,
                         input logic pop, input logic [4:0] n);
        wait_req(tag);
        chk({tag, "_addr"}, bus_if.vlx_addr_o, exp_addr);
        bus_if.ack_i      = 1'b1;
        bus_if.mem_dat_i  = d;
        bus_if.get_bits_i = pop;
        bus_if.nbits_i    = n;
        if (pop) model_pop(n);
        if (act == ACT_APPEND)       begin model_push(d); exp_addr = exp_addr + 32'd1; end
        else if (act == ACT_DISCARD) begin exp_addr = exp_addr + 32'd1; end
        else                         begin model_drop(); end
        sb_push(tag);
        @(posedge clk_i); #1;
        bus_if.ack_i      = 1'b0;
        bus_if.get_bits_i = 1'b0;
        bus_if.nbits_i    = 5'd0;
        sb_check();
    endtask

    task automatic pop_bits(input string tag, input logic [4:0] n);
        bus_if.get_bits_i = 1'b1;
        bus_if.nbits_i    = n;
        model_pop(n);
        sb_push(tag);
        @(posedge clk_i); #1;
        bus_if.get_bits_i = 1'b0;
        bus_if.nbits_i    = 5'd0;
        sb_check();
    endtask

    task automatic set_init(input string tag, input logic [31:0] a);
        bus_if.set_init_addr_i = 1'b1;
        bus_if.dat_i           = a;
        model_q.delete();
        exp_addr = a;
        @(posedge clk_i); #1;
        bus_if.set_init_addr_i = 1'b0;
        chk({tag, "_gap"},  32'(bus_if.load_req_o), 32'd0);
        chk({tag, "_addr"}, bus_if.vlx_addr_o, a);
        chk({tag, "_mark"}, 32'(bus_if.marker_o), 32'd0);
        @(posedge clk_i); #1;
        chk({tag, "_req1"}, 32'(bus_if.load_req_o), 32'd1);
    endtask

    initial begin
        rst_i                  = 1'b0;
        bus_if.set_init_addr_i = 1'b0;
        bus_if.dat_i           = 32'd0;
        bus_if.ack_i           = 1'b0;
        bus_if.mem_dat_i       = 8'd0;
        bus_if.get_bits_i      = 1'b0;
        bus_if.nbits_i         = 5'd0;
        exp_addr               = 32'd0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_addr",  bus_if.vlx_addr_o, 32'd0);
        chk("rst_req",   32'(bus_if.load_req_o), 32'd0);
        chk("rst_bits",  32'(bus_if.bits_o), 32'd0);
        chk("rst_avail", 32'(bus_if.avail_o), 32'd0);
        chk("rst_mark",  32'(bus_if.marker_o), 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Four-byte fill at 0x1000.
        set_init("init1", 32'h0000_1000);
        fetch("f0", 8'hA5, ACT_APPEND, 1'b0, 5'd0);
        fetch("f1", 8'h3C, ACT_APPEND, 1'b0, 5'd0);
        fetch("f2", 8'h0F, ACT_APPEND, 1'b0, 5'd0);
        fetch("f3", 8'hF0, ACT_APPEND, 1'b0, 5'd0);
        chk("fill_bits",  32'(bus_if.bits_o), 32'h0000_A53C);
        chk("fill_avail", 32'(bus_if.avail_o), 32'd32);
        repeat (3) @(posedge clk_i);
        #1;
        chk("full_no_req", 32'(bus_if.load_req_o), 32'd0);

        // Pops, including illegal sizes that must be ignored.
        pop_bits("pop4", 5'd4);
        chk("pop4_const", 32'(bus_if.bits_o), 32'h0000_53C0);
        pop_bits("pop12", 5'd12);
        chk("pop12_const", 32'(bus_if.bits_o), 32'h0000_0FF0);
        chk("pop12_avail", 32'(bus_if.avail_o), 32'd16);
        pop_bits("pop0", 5'd0);
        pop_bits("pop17", 5'd17);

        // Pop and ack in the same cycle.
        fetch("popack", 8'h81, ACT_APPEND, 1'b1, 5'd5);
        chk("popack_avail", 32'(bus_if.avail_o), 32'd19);
        chk("popack_bits",  32'(bus_if.bits_o), 32'h0000_FE10);

        // Restart with a colliding ack.
        wait_req("pre_restart");
        bus_if.set_init_addr_i = 1'b1;
        bus_if.dat_i           = 32'h0000_2000;
        bus_if.ack_i           = 1'b1;
        bus_if.mem_dat_i       = 8'h77;
        model_q.delete();
        exp_addr = 32'h0000_2000;
        @(posedge clk_i); #1;
        bus_if.set_init_addr_i = 1'b0;
        bus_if.ack_i           = 1'b0;
        chk("rs_avail", 32'(bus_if.avail_o), 32'd0);
        chk("rs_bits",  32'(bus_if.bits_o), 32'd0);
        chk("rs_gap",   32'(bus_if.load_req_o), 32'd0);
        chk("rs_addr",  bus_if.vlx_addr_o, 32'h0000_2000);
        fetch("rs_f", 8'h11, ACT_APPEND, 1'b0, 5'd0);
        pop_bits("pop9_over", 5'd9);
        pop_bits("pop8", 5'd8);

        // Stuffed stream FF 00 12 FF D9.
        set_init("init3", 32'h0000_3000);
`ifdef OR1200_VLX_LU_UNSTUFF_EN
        fetch("s0", 8'hFF, ACT_APPEND,  1'b0, 5'd0);
        fetch("s1", 8'h00, ACT_DISCARD, 1'b0, 5'd0);
        fetch("s2", 8'h12, ACT_APPEND,  1'b0, 5'd0);
        fetch("s3", 8'hFF, ACT_APPEND,  1'b0, 5'd0);
        fetch("s4", 8'hD9, ACT_MARKER,  1'b0, 5'd0);
        chk("mk_bits",  32'(bus_if.bits_o), 32'h0000_FF12);
        chk("mk_flag",  32'(bus_if.marker_o), 32'd1);
        chk("mk_addr",  bus_if.vlx_addr_o, 32'h0000_3004);
        repeat (4) @(posedge clk_i);
        #1;
        chk("mk_noreq", 32'(bus_if.load_req_o), 32'd0);
        chk("mk_hold",  32'(bus_if.marker_o), 32'd1);
        pop_bits("mk_drain", 5'd16);
        chk("mk_after", 32'(bus_if.marker_o), 32'd1);
`else
        fetch("s0", 8'hFF, ACT_APPEND, 1'b0, 5'd0);
        fetch("s1", 8'h00, ACT_APPEND, 1'b0, 5'd0);
        fetch("s2", 8'h12, ACT_APPEND, 1'b0, 5'd0);
        fetch("s3", 8'hFF, ACT_APPEND, 1'b0, 5'd0);
        chk("raw_bits", 32'(bus_if.bits_o), 32'h0000_FF00);
        chk("raw_mark", 32'(bus_if.marker_o), 32'd0);
        pop_bits("raw_pop", 5'd16);
        fetch("s4", 8'hD9, ACT_APPEND, 1'b0, 5'd0);
        chk("raw_bits2", 32'(bus_if.bits_o), 32'h0000_12FF);
        chk("raw_mark2", 32'(bus_if.marker_o), 32'd0);
`endif

        // Asynchronous reset between edges while a fetch is pending.
        set_init("init4", 32'h0000_4000);
        fetch("r0", 8'h5A, ACT_APPEND, 1'b0, 5'd0);
        wait_req("r1");
        #3;
        rst_i = 1'b0;
        #1;
        chk("arst_addr",  bus_if.vlx_addr_o, 32'd0);
        chk("arst_req",   32'(bus_if.load_req_o), 32'd0);
        chk("arst_bits",  32'(bus_if.bits_o), 32'd0);
        chk("arst_avail", 32'(bus_if.avail_o), 32'd0);
        chk("arst_mark",  32'(bus_if.marker_o), 32'd0);
        #2;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/or1200_vlx_lu.md
# or1200_vlx_lu

VLX load unit: the read-side counterpart of the VLX store unit in the OR1200 JPEG accelerator path. After software sets a start address, it fetches a byte stream from memory one byte at a time. Fetched bytes go into a 32-bit MSB-first bit buffer. A Huffman decoder then consumes 1–16 bits per pop. When compiled with unstuffing, it removes JPEG 0xFF00 stuffing and halts on markers.

## Interface
Parameters: none (widths fixed by package constants).
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- set_init_addr_i  in  1  load start address from dat_i, flush buffer, restart
- dat_i  in  32  start byte address (sampled with set_init_addr_i)
- vlx_addr_o  out  32  byte address of current/next fetch
- load_req_o  out  1  byte read request; held until ack_i
- ack_i  in  1  single-cycle read completion
- mem_dat_i  in  8  read byte, valid with ack_i
- get_bits_i  in  1  consumer pops nbits_i bits this cycle
- nbits_i  in  5  pop size, 1..16
- bits_o  out  16  next 16 buffer bits, MSB = oldest bit
- avail_o  out  6  valid bit count in buffer, 0..32
- marker_o  out  1  marker detected, fetching stopped

## Operation
- State machine has four states: IDLE, REQ, CHK_FF, MARKER.
- REQ: `load_req_o`=1 and `vlx_addr_o` held stable. On `ack_i`, the byte is appended at bit position avail, avail += 8, address += 1, and the next state is IDLE.
- IDLE: go to REQ when avail ≤ 24. Otherwise stay in IDLE.
- Unstuffing (compiled in):
  - A byte 0xFF acked in REQ is appended like any other byte, then the FSM goes to CHK_FF.
  - CHK_FF issues the next read. If that byte is 0x00, it is discarded, the address increments, and the FSM goes to IDLE.
  - If that byte is non-zero, the FSM goes to MARKER. The marker byte is not appended, and the preceding 0xFF is removed (avail −= 8). The address is left pointing at the marker byte.
- MARKER: `marker_o`=1, no requests. The buffer can still be drained. The FSM exits only on `set_init_addr_i`.
- Pop: when `get_bits_i` and nbits_i ≤ avail, shift the buffer left by nbits_i and set avail −= nbits_i. If nbits_i > avail, or nbits_i is 0, the pop is ignored with no state change.
- Simultaneous pop and ack: the pop shift applies first, then the byte is inserted at position (avail − nbits_i); avail += 8 − nbits_i.
- `set_init_addr_i` from any state has priority:
  - address = dat_i, buffer and avail cleared, marker_o cleared, next state REQ.
  - An ack_i arriving in the same cycle is discarded.
  - A request in flight is withdrawn: `load_req_o` drops for exactly one cycle before re-asserting at the new address.
- Reset mid-operation: everything clears immediately, asynchronously.
- `vlx_addr_o` is 32-bit and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values: vlx_addr_o=0, load_req_o=0, bits_o=0, avail_o=0, marker_o=0, state IDLE.
- All outputs are registered.
- `load_req_o` is first asserted 1 cycle after `set_init_addr_i` is sampled.
- A byte acked at edge t is visible on bits_o/avail_o after edge t.
- The next request asserts no earlier than 1 cycle after an ack, because the FSM passes through IDLE. Sustained rate is therefore one byte per (bus latency + 1) cycles.
- A pop at edge t is reflected on bits_o after edge t, so back-to-back pops every cycle are supported.

## Configuration
- `OR1200_VLX_LU_UNSTUFF_EN` defined: the CHK_FF and MARKER states exist, 0xFF00 is unstuffed, and markers halt fetching.
- Not defined: 0xFF is ordinary data, the FSM has only IDLE and REQ, and `marker_o` is tied to 0.

## Structure
- Package `or1200_vlx_pkg` holds:
  - state enum `vlx_lu_state_t`
  - `VLX_BUF_W`=32
  - `VLX_FETCH_THRESH`=24
  - `VLX_STUFF_BYTE`=8'hFF
  - `VLX_MAX_POP`=16
- One sub-module, `or1200_vlx_bitbuf`: the 32-bit shift buffer with its count. It takes inputs push/byte and pop/n, and outputs bits and avail.

## Test plan
- Set address 0x1000 over memory bytes A5 3C 0F F0 → requests go to 0x1000..0x1003; after 4 acks avail=32 and bits_o=0xA53C.
- Pop 4 then 12 from that state → bits_o=0x53C0, then 0x0FF0, with avail=28 then 16.
- Simultaneous pop of 5 with an ack of byte 0x81 at avail=16 → avail=19, and the new byte lands at bit position 11.
- With unstuffing on, stream FF 00 12 FF D9 →
  - the data bits read FF 12
  - the stuffed 00 byte is discarded
  - marker_o=1 after D9 is read
  - vlx_addr_o = address of D9
  - no further requests are issued.
- `set_init_addr_i` with dat_i=0x2000 during REQ with ack_i in the same cycle → the ack is ignored, avail=0, and the next request goes to 0x2000.
- Assert rst_i low mid-fetch, asynchronously between edges → all outputs read reset values immediately.
